// File: rtl/xxd_pkg.sv
// Shared constants and line-format FSM state type for the xxd reverse decoder.
package xxd_pkg;

    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_NL    = 8'h0A;

    typedef enum logic [1:0] {
        OFFSET = 2'd0,
        HEX    = 2'd1,
        ASCII  = 2'd2
    } line_state_t;

endpackage

// File: rtl/xxd_hex_nibble.sv
// Combinational ASCII hex-digit decoder: one character in, nibble value plus a hex flag out.
module xxd_hex_nibble (
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nibble = ch[3:0];
            is_hex = 1'b1;
        end else if ((ch >= 8'h61 && ch <= 8'h66) || (ch >= 8'h41 && ch <= 8'h46)) begin
            // 'a'/'A' have low bits 1, so adding 9 maps them onto 10..15
            nibble = ch[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/xxd_reverse.sv
// Streaming hex-to-binary decoder (xxd -r / xxd -r -p) with a single-entry
// output register and valid/ready handshakes on both sides.
module xxd_reverse
    import xxd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] byte_count,
    output logic             err
);

    logic        mode_r;
    line_state_t state, state_n;
    logic        prev_space, prev_space_n;
    logic [3:0]  hi_nib, hi_nib_n;
    logic        hi_vld, hi_vld_n;
    logic        emit, err_set, pair;
    logic [3:0]  nib;
    logic        is_hex;
    logic        in_fire, out_fire;

    xxd_hex_nibble u_nibble (
        .ch     (in_data),
        .nibble (nib),
        .is_hex (is_hex)
    );

    assign in_ready = !rst && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_n      = state;
        prev_space_n = prev_space;
        hi_nib_n     = hi_nib;
        hi_vld_n     = hi_vld;
        emit         = 1'b0;
        err_set      = 1'b0;
        pair         = 1'b0;
        if (in_fire) begin
            if (!mode_r) begin
                pair = is_hex;
            end else begin
                case (state)
                    OFFSET: begin
                        if (in_data == CH_COLON) begin
                            state_n      = HEX;
                            prev_space_n = 1'b0;
                        end
                    end
                    HEX: begin
                        if (is_hex) begin
                            pair         = 1'b1;
                            prev_space_n = 1'b0;
                        end else if (in_data == CH_SPACE) begin
                            // A lone space separates groups; a second one starts the ASCII column
                            if (prev_space) begin
                                state_n      = ASCII;
                                prev_space_n = 1'b0;
                                hi_vld_n     = 1'b0;
                            end else begin
                                prev_space_n = 1'b1;
                            end
                        end else if (in_data == CH_NL) begin
                            state_n      = OFFSET;
                            prev_space_n = 1'b0;
                            hi_vld_n     = 1'b0;
                        end else begin
                            err_set      = 1'b1;
                            state_n      = ASCII;
                            prev_space_n = 1'b0;
                            hi_vld_n     = 1'b0;
                        end
                    end
                    ASCII: begin
                        if (in_data == CH_NL) begin
                            state_n      = OFFSET;
                            prev_space_n = 1'b0;
                        end
                    end
                    default: begin
                        state_n      = OFFSET;
                        prev_space_n = 1'b0;
                    end
                endcase
            end
            if (pair) begin
                if (hi_vld) begin
                    emit     = 1'b1;
                    hi_vld_n = 1'b0;
                end else begin
                    hi_nib_n = nib;
                    hi_vld_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r     <= mode;
            state      <= OFFSET;
            prev_space <= 1'b0;
            hi_nib     <= 4'h0;
            hi_vld     <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            byte_count <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            prev_space <= prev_space_n;
            hi_nib     <= hi_nib_n;
            hi_vld     <= hi_vld_n;
            // A new byte overrides the drain of the old one so there is no bubble
            if (emit) begin
                out_data  <= {hi_nib, nib};
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (out_fire) byte_count <= byte_count + CNT_W'(1);
            if (err_set) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xxd_reverse.sv
// Bench for xxd_reverse: table of decode vectors plus stall, reset and counter-wrap sequences.
module tb_xxd_reverse;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] byte_count;
    logic        err;

    logic        in_ready4;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic [3:0]  byte_count4;
    logic        err4;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    xxd_reverse dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .byte_count (byte_count),
        .err        (err)
    );

    xxd_reverse #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready4),
        .out_data   (out_data4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready),
        .byte_count (byte_count4),
        .err        (err4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every output transfer against the next expected byte
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %02h, expected none", out_data);
            end else begin
                check("out_byte", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
            end
        end
    end

    task automatic send_char(input logic [7:0] c);
        bit accepted;
        int t;
        in_data  = c;
        in_valid = 1'b1;
        accepted = 1'b0;
        t = 0;
        while (!accepted && t < 200) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready, expected acceptance of %02h", c);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (sb_q.size() != 0 || out_valid); t++) begin
            @(posedge clk);
            #2;
        end
        check("drain_left", sb_q.size(), 0);
    endtask

    task automatic do_reset(input logic m);
        rst      = 1'b1;
        mode     = m;
        in_valid = 1'b0;
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 0);
        check("rst_out_valid", {31'h0, out_valid}, 0);
        check("rst_out_data", {24'h0, out_data}, 0);
        check("rst_count", {16'h0, byte_count}, 0);
        check("rst_err", {31'h0, err}, 0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        mode;
        string       s;
        int          n;
        logic [63:0] b;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{1'b0, "48 65\n6c6C6f", 5, 64'h48656C6C6F, 1'b0};
        vecs[1] = '{1'b1, "00000000: 4865 6c6c 6f0a  Hello.\n", 6, 64'h48656C6C6F0A, 1'b0};
        vecs[2] = '{1'b1, "00000000: 4g\n00000010: ff\n", 1, 64'hFF, 1'b1};
        vecs[3] = '{1'b0, "zA: B", 1, 64'hAB, 1'b0};
        vecs[4] = '{1'b1, "0: a  b\n1: 12 3\n", 1, 64'h12, 1'b0};
        vecs[5] = '{1'b1, "\n\n0:ff\n", 1, 64'hFF, 1'b0};
        vecs[6] = '{1'b0, "abcdef01", 4, 64'hABCDEF01, 1'b0};

        for (int v = 0; v < 7; v++) begin
            do_reset(vecs[v].mode);
            out_ready = 1'b1;
            for (int i = 0; i < vecs[v].n; i++)
                sb_q.push_back(vecs[v].b[8*(vecs[v].n-1-i) +: 8]);
            send_str(vecs[v].s);
            drain();
            check($sformatf("vec%0d_count", v), {16'h0, byte_count}, vecs[v].n);
            check($sformatf("vec%0d_err", v), {31'h0, err}, {31'h0, vecs[v].err});
        end

        // Backpressure: 0xAB held through a 10-cycle stall, then both bytes in order
        do_reset(1'b0);
        out_ready = 1'b0;
        sb_q.push_back(8'hAB);
        sb_q.push_back(8'hCD);
        send_str("ab");
        in_data  = 8'h20;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_valid", {31'h0, out_valid}, 1);
            check("stall_data", {24'h0, out_data}, 32'hAB);
            check("stall_in_ready", {31'h0, in_ready}, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_str(" cd");
        drain();
        check("stall_count", {16'h0, byte_count}, 2);

        // Reset with a held byte and a blocked character, then mid-byte reset
        do_reset(1'b0);
        out_ready = 1'b0;
        send_str("12");
        in_data  = "a";
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'h0, out_valid}, 0);
        check("midrst_count", {16'h0, byte_count}, 0);
        check("midrst_in_ready", {31'h0, in_ready}, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        send_char("5");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.push_back(8'h34);
        send_str("34");
        drain();
        check("postrst_count", {16'h0, byte_count}, 1);
        check("postrst_err", {31'h0, err}, 0);

        // Counter wrap on the 4-bit instance
        do_reset(1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            sb_q.push_back(i[7:0]);
            send_str($sformatf("%02x", i));
        end
        drain();
        check("wrap_count16", {16'h0, byte_count}, 17);
        check("wrap_count4", {28'h0, byte_count4}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xxd_reverse.md
XXD_REVERSE -- requirements
Module: xxd_reverse

Interface
REQ-001 Parameter CNT_W, default 16, width of the emitted-byte counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mode  input  1  0 = plain hex stream (xxd -r -p), 1 = xxd line format (xxd -r); captured while rst is high.
REQ-005 in_data  input  8  ASCII character from the upstream stream.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data; a character transfers when in_valid && in_ready.
REQ-008 out_data  output  8  decoded binary byte.
REQ-009 out_valid  output  1  out_data valid; held until out_ready.
REQ-010 out_ready  input  1  downstream accepts out_data; a byte transfers when out_valid && out_ready.
REQ-011 byte_count  output  CNT_W  number of bytes transferred on the output since reset.
REQ-012 err  output  1  sticky flag: illegal character in a hex field (line mode only).

Function
REQ-013 Hex digits are '0'-'9', 'a'-'f' and 'A'-'F'; the first digit of a pair is the high nibble and the second is the low nibble.
REQ-014 in_ready = !out_valid || out_ready (combinational); a single-entry output register, no further buffering.
REQ-015 Latency: out_valid rises the cycle after the low-nibble character transfers; out_data is stable while out_valid && !out_ready.
REQ-016 Simultaneous output transfer and input low-nibble transfer in one cycle: out_valid stays 1 and out_data loads the new byte; no bubble.
REQ-017 Plain mode: every non-hex character is ignored; a pending high nibble survives across ignored characters.
REQ-018 Line-mode FSM states: OFFSET, HEX, ASCII.
REQ-019 OFFSET: discard characters; ':' -> HEX; '\n' -> stay in OFFSET.
REQ-020 HEX: digits pair into bytes; a single space is a group separator and is ignored.
REQ-021 HEX: two consecutive spaces -> ASCII; a pending high nibble is discarded.
REQ-022 HEX: '\n' -> OFFSET; a pending high nibble is discarded.
REQ-023 HEX: any other character sets err, discards any pending nibble -> ASCII.
REQ-024 ASCII: discard characters until '\n' -> OFFSET.
REQ-025 The "previous character was space" flag clears on any non-space character and on every state change.
REQ-026 byte_count increments by 1 per output transfer and wraps modulo 2^CNT_W.
REQ-027 err, once set, stays set until reset.

Reset
REQ-028 While rst is high: out_valid=0, out_data=0x00, byte_count=0, err=0, pending nibble cleared, FSM=OFFSET, mode register loaded from mode.
REQ-029 rst asserted mid-byte or with out_valid=1 drops the pending nibble and the held byte; nothing is emitted.
REQ-030 in_ready is 0 while rst is high.

Structure
REQ-031 Shared package xxd_pkg holds: ASCII constants (':', space, '\n') and the line-FSM state enum (OFFSET, HEX, ASCII).
REQ-032 One combinational sub-module, xxd_hex_nibble: 8-bit ASCII in, 4-bit nibble plus is_hex out.
REQ-033 Target size 120-400 lines of RTL.

Verification
REQ-034 Plain: "48 65\n6c6C6f" with out_ready=1 -> bytes 0x48,0x65,0x6C,0x6C,0x6F; byte_count=5; err=0.
REQ-035 Line: "00000000: 4865 6c6c 6f0a  Hello.\n" -> bytes 0x48,0x65,0x6C,0x6C,0x6F,0x0A; offset and ASCII-column digits emit nothing.
REQ-036 Backpressure: out_ready=0 for 10 cycles while streaming "ab cd" -> 0xAB held stable, in_ready=0 during the stall, then 0xAB and 0xCD in order with no loss.
REQ-037 Line error: "00000000: 4g\n00000010: ff\n" -> err=1; pending nibble 4 dropped; 0xFF emitted as the only byte.
REQ-038 Reset: assert rst after 'a' with out_valid=1 holding 0x12 -> out_valid=0, byte_count=0, FSM=OFFSET; then stream "34" (plain) -> 0x34 only.
REQ-039 Wrap: CNT_W=4, stream 17 bytes -> byte_count reads 1.
